// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampled UART receive deframer with 3-sample majority vote and start/parity/stop checks
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_Err,
  output logic                  Stop_Err,
  output logic                  rx_busy
);
  localparam int EW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0 = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_S1 = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] E_S2 = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_nxt;
  logic [EW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [2:0] samp;
  logic par_pend, last, maj, done, good;
  // state register
  always_ff @(posedge CLK)
    state <= !RST ? IDLE : state_nxt;
  // next-state: every bit decision happens on the last cycle of the bit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !RX_IN ? START : IDLE;
      START:   state_nxt = last ? (maj ? IDLE : DATA) : START;
      DATA:    state_nxt = (last && bit_cnt == B_LAST) ? (PAR_EN ? PAR : STOP) : DATA;
      PAR:     state_nxt = last ? STOP : PAR;
      STOP:    state_nxt = last ? IDLE : STOP;
      default: state_nxt = IDLE;
    endcase
  end
  // decoded bit value and end-of-frame decisions
  always_comb begin
    last = edge_cnt == E_LAST;
    maj = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    done = state == STOP && last;
    good = done && maj && !par_pend;
    rx_busy = state != IDLE;
  end
  // bit timing, sampling, shifting and registered result pulses
  always_ff @(posedge CLK) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
      samp <= '0;
      shift_reg <= '0;
      par_pend <= 1'b0;
      P_DATA <= '0;
      Data_Valid <= 1'b0;
      Par_Err <= 1'b0;
      Stop_Err <= 1'b0;
    end else begin
      edge_cnt <= (state == IDLE) ? EW'(!RX_IN) : (last ? '0 : edge_cnt + 1'b1);
      bit_cnt <= (state == DATA) ? (last ? bit_cnt + 1'b1 : bit_cnt) : '0;
      if (edge_cnt == E_S0) samp[0] <= RX_IN;
      if (edge_cnt == E_S1) samp[1] <= RX_IN;
      if (edge_cnt == E_S2) samp[2] <= RX_IN;
      if (state == DATA && last) shift_reg <= (shift_reg >> 1) | (DATA_WIDTH'(maj) << (DATA_WIDTH - 1));
      par_pend <= done ? 1'b0 : ((state == PAR && last && (maj != (^shift_reg ^ PAR_TYP))) ? 1'b1 : par_pend);
      Data_Valid <= good;
      Par_Err <= done && par_pend;
      Stop_Err <= done && !maj;
      if (good) P_DATA <= shift_reg;
    end
  end
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed self-checking bench for the UART receive deframer
module tb_uart_rx_deframer;
  localparam int P = 8;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic RX_IN = 1'b1;
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic Data_Valid, Par_Err, Stop_Err, rx_busy;
  int tests = 0;
  int fails = 0;
  logic f_dv;
  logic [7:0] f_pd;
  always #5 CLK = ~CLK;
  uart_rx_deframer #(.DATA_WIDTH(8), .PRESCALE(P)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_Err(Par_Err), .Stop_Err(Stop_Err), .rx_busy(rx_busy)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic r);
    @(posedge CLK);
    #1;
    RX_IN = v;
    RST = r;
    @(negedge CLK);
  endtask
  function automatic logic frame_val(input logic [7:0] d, input logic pe, input logic pb, input logic sb, input int c);
    int b;
    b = c / P;
    return (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : (pe && b == 9) ? pb : sb;
  endfunction
  task automatic send(input string tag, input logic [7:0] d, input logic pb, input logic sb, input int flip);
    int n, early, gaps;
    logic v;
    n = (10 + int'(PAR_EN)) * P;
    early = 0;
    gaps = 0;
    for (int c = 0; c < n; c++) begin
      v = frame_val(d, PAR_EN, pb, sb, c);
      step(c == flip ? !v : v, 1'b1);
      if (c == 0) begin
        f_dv = Data_Valid;
        f_pd = P_DATA;
      end else begin
        if (Data_Valid || Par_Err || Stop_Err) early++;
        if (!rx_busy) gaps++;
      end
    end
    check({tag, " early_pulse"}, early, 0);
    check({tag, " busy_gap"}, gaps, 0);
  endtask
  task automatic finish_check(input string tag, input logic dv, input logic pe, input logic se, input logic [7:0] pd);
    step(1'b1, 1'b1);
    check({tag, " dv"}, Data_Valid, dv);
    check({tag, " par_err"}, Par_Err, pe);
    check({tag, " stop_err"}, Stop_Err, se);
    check({tag, " p_data"}, P_DATA, pd);
    check({tag, " busy_end"}, rx_busy, 0);
    step(1'b1, 1'b1);
    check({tag, " pulse_width"}, {Data_Valid, Par_Err, Stop_Err}, 0);
  endtask
  initial begin
    int cnt;
    repeat (3) step(1'b1, 1'b0);
    check("rst p_data", P_DATA, 0);
    check("rst dv", Data_Valid, 0);
    check("rst par_err", Par_Err, 0);
    check("rst stop_err", Stop_Err, 0);
    check("rst busy", rx_busy, 0);
    repeat (2) step(1'b1, 1'b1);
    send("a5", 8'hA5, 1'b0, 1'b1, -1);
    finish_check("a5", 1'b1, 1'b0, 1'b0, 8'hA5);
    PAR_EN = 1'b1;
    PAR_TYP = 1'b0;
    send("3c_ok", 8'h3C, 1'b0, 1'b1, -1);
    finish_check("3c_ok", 1'b1, 1'b0, 1'b0, 8'h3C);
    send("3c_bad", 8'h3C, 1'b1, 1'b1, -1);
    finish_check("3c_bad", 1'b0, 1'b1, 1'b0, 8'h3C);
    PAR_EN = 1'b0;
    send("81_stop", 8'h81, 1'b0, 1'b0, -1);
    finish_check("81_stop", 1'b0, 1'b0, 1'b1, 8'h3C);
    cnt = 0;
    for (int c = 0; c <= 8; c++) begin
      step(c < 2 ? 1'b0 : 1'b1, 1'b1);
      if (c >= 1 && (Data_Valid || Par_Err || Stop_Err)) cnt++;
      if (c == 1) check("glitch busy_c1", rx_busy, 1);
      if (c == 8) check("glitch busy_c8", rx_busy, 0);
    end
    check("glitch pulses", cnt, 0);
    send("5a", 8'h5A, 1'b0, 1'b1, -1);
    finish_check("5a", 1'b1, 1'b0, 1'b0, 8'h5A);
    send("00_flip", 8'h00, 1'b0, 1'b1, 36);
    finish_check("00_flip", 1'b1, 1'b0, 1'b0, 8'h00);
    send("55", 8'h55, 1'b0, 1'b1, -1);
    send("aa", 8'hAA, 1'b0, 1'b1, -1);
    check("b2b 55 dv", f_dv, 1);
    check("b2b 55 p_data", f_pd, 8'h55);
    finish_check("aa", 1'b1, 1'b0, 1'b0, 8'hAA);
    cnt = 0;
    for (int c = 0; c < 10 * P; c++) begin
      step(frame_val(8'hFF, 1'b0, 1'b0, 1'b1, c), c != 42);
      if (c >= 1 && (Data_Valid || Par_Err || Stop_Err)) cnt++;
      if (c == 43) begin
        check("midrst p_data", P_DATA, 0);
        check("midrst busy", rx_busy, 0);
        check("midrst dv", Data_Valid, 0);
      end
    end
    step(1'b1, 1'b1);
    if (Data_Valid || Par_Err || Stop_Err) cnt++;
    check("midrst pulses", cnt, 0);
    send("12", 8'h12, 1'b0, 1'b1, -1);
    finish_check("12", 1'b1, 1'b0, 1'b0, 8'h12);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_deframer.md
# uart_rx_deframer

UART receive deframer: recovers bytes from the serial line driven by the team's UART transmitter (start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit). It runs on an oversampling clock of PRESCALE cycles per bit. Each bit is sampled with a 3-sample majority vote, and the block checks start, parity and stop bits. It delivers a parallel word with a one-cycle valid pulse, or a one-cycle error pulse, to the downstream consumer.

## Interface
- DATA_WIDTH, 8: data bits per frame.
- PRESCALE, 8: CLK cycles per bit; even, at least 8.
- CLK  in  1  oversampling clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-low.
- RX_IN  in  1  serial line, idle high; synchronous to CLK, no internal synchronizer.
- PAR_EN  in  1  1 = parity bit present after data.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  last good word; holds until next good frame.
- Data_Valid  out  1  one-cycle pulse, P_DATA updated this cycle.
- Par_Err  out  1  one-cycle pulse, parity mismatch.
- Stop_Err  out  1  one-cycle pulse, stop bit sampled 0.
- rx_busy  out  1  high whenever state is not IDLE.

## Operation
- The state register holds one of five states: IDLE, START, DATA, PAR, STOP.
- edge_cnt (0..PRESCALE-1) counts cycles within a bit. It wraps to 0 after PRESCALE-1. bit_cnt counts data bits.
- IDLE:
  - RX_IN == 0 is the detection cycle, which counts as edge index 0.
  - Next state is START with edge_cnt = 1.
- Sampling:
  - RX_IN is captured at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - The sampled bit is the majority of the three captures.
  - All bit decisions are made at edge_cnt = PRESCALE-1.
- START: sampled bit 1 means a glitch; go to IDLE with no output pulse. Sampled bit 0 means go to DATA with bit_cnt = 0.
- DATA: at the end of each bit, shift the sampled bit in LSB-first. After DATA_WIDTH bits, go to PAR if PAR_EN is 1, else go to STOP.
- PAR:
  - Expected parity = XOR of data bits XOR PAR_TYP.
  - On mismatch, record a pending parity error.
  - Go to STOP in all cases.
- STOP, at the end of the stop bit, the state returns to IDLE and pulses register for the next cycle:
  - Stop sampled 1 and no pending parity error: load P_DATA and pulse Data_Valid.
  - Stop sampled 0: pulse Stop_Err.
  - Pending parity error: pulse Par_Err.
  - Par_Err and Stop_Err may pulse together. Data_Valid never pulses together with either error.
- PAR_EN and PAR_TYP are sampled continuously. They must be stable from START through the end of STOP.
- Reset (RST low at a CLK edge):
  - State goes to IDLE; edge_cnt, bit_cnt, shift register and pending error clear.
  - All outputs are 0: P_DATA = 0, Data_Valid = 0, Par_Err = 0, Stop_Err = 0, rx_busy = 0.
  - Reset mid-frame aborts the frame with no pulse. Reception resumes at the next falling edge after RST goes high.

## Timing
- Let the detection cycle be cycle 0 and N = 2 + DATA_WIDTH + PAR_EN, the frame length in bits.
- The last stop-bit cycle is N*PRESCALE-1. Data_Valid, Par_Err and Stop_Err are high only in cycle N*PRESCALE, for exactly one cycle.
- rx_busy is high in cycles 1..N*PRESCALE-1 and low in cycle N*PRESCALE.
- Back-to-back frames:
  - The receiver is in IDLE exactly at the first cycle of the next start bit, so the next frame is detected in the same cycle the output pulse is high.
  - No idle gap is required between frames.
- Glitch rejection: a false start returns to IDLE in cycle PRESCALE.
- Majority vote: any single corrupted sample among the three captures of a bit does not change the decoded value.

## Test plan
- Reset, then send 0xA5 with PRESCALE=8 and PAR_EN=0 -> Data_Valid high only in cycle 80, P_DATA=0xA5, no error pulses, rx_busy low at cycle 80.
- Send 0x3C with PAR_EN=1, PAR_TYP=0 and parity bit 0 -> Data_Valid in cycle 88, P_DATA=0x3C. Repeat with parity bit 1 -> Par_Err pulse in cycle 88, Data_Valid stays 0, P_DATA stays 0x3C.
- Send 0x81 with the stop bit driven 0 -> Stop_Err pulse in cycle 80, no Data_Valid, P_DATA unchanged.
- Drive RX_IN low for 2 cycles, then high -> no pulses, rx_busy falls at cycle 8. Then send 0x5A -> P_DATA=0x5A.
- Send 0x00 with one sample inverted at edge index 4 of data bit 3 -> P_DATA=0x00 with Data_Valid. Then send 0x55 and 0xAA back-to-back with no gap -> two Data_Valid pulses 80 cycles apart, values 0x55 then 0xAA.
- Assert RST for one cycle during data bit 4 of 0xFF -> no pulses, all outputs 0. The next frame 0x12 is received correctly.
